// File: rtl/fdct_8x8_pkg.sv
// Shared constants for the 8x8 forward DCT: word widths, FSM encoding and
// the DCT-II basis quantised to round(C * 2^12).
package fdct_8x8_pkg;

  localparam int COEF_W = 13;
  localparam int FRAC   = 12;
  localparam int TMP_W  = 16;
  localparam int OUT_W  = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;

  // cos(n*pi/16) terms; row 0 uses sqrt(1/8), which equals 0.5*cos(4*pi/16)
  localparam int C1 = 2009;
  localparam int C2 = 1892;
  localparam int C3 = 1703;
  localparam int C4 = 1448;
  localparam int C5 = 1138;
  localparam int C6 = 784;
  localparam int C7 = 400;

  localparam int COEF_TBL [8][8] = '{
    '{ C4,  C4,  C4,  C4,  C4,  C4,  C4,  C4},
    '{ C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1},
    '{ C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2},
    '{ C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3},
    '{ C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4},
    '{ C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5},
    '{ C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6},
    '{ C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7}
  };

endpackage

// File: rtl/fdct_8x8_if.sv
// Host-side bundle of the 8x8 DCT: block request, pixel-row fetch and the
// coefficient output stream with its status flags.
interface fdct_8x8_if #(
  parameter int OUT_W = fdct_8x8_pkg::OUT_W
);

  logic                    start;
  logic [2:0]              rd_row;
  logic [63:0]             pix_row;
  logic signed [OUT_W-1:0] coef_out;
  logic [2:0]              coef_u;
  logic [2:0]              coef_v;
  logic                    coef_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output start, pix_row,
    input  rd_row, coef_out, coef_u, coef_v, coef_valid, busy, done
  );

  modport slave (
    input  start, pix_row,
    output rd_row, coef_out, coef_u, coef_v, coef_valid, busy, done
  );

endinterface

// File: rtl/dct_coef_rom.sv
// Combinational lookup of one row of the quantised DCT basis; element k of
// the row occupies bits [k*COEF_W +: COEF_W].
module dct_coef_rom #(
  parameter int COEF_W = fdct_8x8_pkg::COEF_W
) (
  input  logic [2:0]          addr,
  output logic [8*COEF_W-1:0] row
);

  import fdct_8x8_pkg::*;

  always_comb begin
    row = '0;
    for (int unsigned k = 0; k < 8; k++)
      row[k*COEF_W +: COEF_W] = COEF_W'(COEF_TBL[addr][k]);
  end

endmodule

// File: rtl/fdct_8x8.sv
// Two-pass 8x8 forward DCT, Y = C*X*C^T: pass 1 builds the transposed row
// transform in Tt, pass 2 applies the column transform and streams results.
module fdct_8x8 #(
  parameter int COEF_W = fdct_8x8_pkg::COEF_W,
  parameter int TMP_W  = fdct_8x8_pkg::TMP_W,
  parameter int OUT_W  = fdct_8x8_pkg::OUT_W
) (
  input logic       clk,
  input logic       rst,
  fdct_8x8_if.slave bus
);

  import fdct_8x8_pkg::*;

  localparam int ACC1_W  = 25;
  localparam int ACC2_W  = 32;
  localparam int RND     = 1 << (FRAC - 1);
  localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (OUT_W - 1));

  logic [1:0]               state;
  logic [2:0]               i;
  logic [2:0]               j;
  logic                     last;

  logic [8*COEF_W-1:0]      row_p1;
  logic [8*COEF_W-1:0]      row_p2;
  logic signed [COEF_W-1:0] c_p1 [8];
  logic signed [COEF_W-1:0] c_p2 [8];
  logic signed [8:0]        x    [8];
  logic signed [TMP_W-1:0]  tt   [8][8];

  logic signed [ACC1_W-1:0] acc1;
  logic signed [TMP_W-1:0]  t_val;
  logic signed [ACC2_W-1:0] acc2;
  logic signed [ACC2_W-1:0] y_shr;
  logic signed [OUT_W-1:0]  y_sat;

  logic signed [OUT_W-1:0]  coef_q;
  logic [2:0]               u_q;
  logic [2:0]               v_q;
  logic                     valid_q;
  logic                     done_q;

  // Pass 1 needs basis row j, pass 2 basis row i; two lookups avoid a mux.
  dct_coef_rom #(.COEF_W(COEF_W)) u_rom_p1 (.addr(j), .row(row_p1));
  dct_coef_rom #(.COEF_W(COEF_W)) u_rom_p2 (.addr(i), .row(row_p2));

  assign last = (i == 3'd7) && (j == 3'd7);

  always_comb begin : pass1_dp
    acc1 = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      x[k]    = signed'({1'b0, bus.pix_row[8*k +: 8]}) - 9'sd128;
      c_p1[k] = row_p1[k*COEF_W +: COEF_W];
      acc1    = acc1 + ACC1_W'(x[k]) * ACC1_W'(c_p1[k]);
    end
    t_val = TMP_W'((acc1 + ACC1_W'(RND)) >>> FRAC);
  end

  always_comb begin : pass2_dp
    acc2 = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      c_p2[k] = row_p2[k*COEF_W +: COEF_W];
      acc2    = acc2 + ACC2_W'(c_p2[k]) * ACC2_W'(tt[j][k]);
    end
    y_shr = (acc2 + ACC2_W'(RND)) >>> FRAC;
    if (y_shr > SAT_MAX)
      y_sat = OUT_W'(SAT_MAX);
    else if (y_shr < SAT_MIN)
      y_sat = OUT_W'(SAT_MIN);
    else
      y_sat = OUT_W'(y_shr);
  end

  // Tt keeps no reset: an abandoned block leaves stale data that the next
  // block fully overwrites before pass 2 reads it.
  always_ff @(posedge clk) begin
    if (state == S_PASS1)
      tt[j][i] <= t_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      i       <= '0;
      j       <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      coef_q  <= '0;
      u_q     <= '0;
      v_q     <= '0;
    end else begin
      valid_q <= (state == S_PASS2);
      done_q  <= (state == S_PASS2) && last;
      if (state == S_PASS2) begin
        coef_q <= y_sat;
        u_q    <= i;
        v_q    <= j;
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_PASS1;
            i     <= '0;
            j     <= '0;
          end
        end
        S_PASS1, S_PASS2: begin
          j <= j + 3'd1;
          if (j == 3'd7)
            i <= i + 3'd1;
          if (last)
            state <= (state == S_PASS1) ? S_PASS2 : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_row     = (state == S_PASS1) ? i : '0;
  assign bus.busy       = (state != S_IDLE);
  assign bus.coef_out   = coef_q;
  assign bus.coef_u     = u_q;
  assign bus.coef_v     = v_q;
  assign bus.coef_valid = valid_q;
  assign bus.done       = done_q;

endmodule

// File: doc/fdct_8x8.md
FDCT_8X8 -- requirements
Module: fdct_8x8

Interface
REQ-001 Parameter COEF_W, default 13: signed DCT coefficient width, fraction bits FRAC=12.
REQ-002 Parameter TMP_W, default 16: signed intermediate (pass-1) word width.
REQ-003 Parameter OUT_W, default 12: signed output coefficient width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request to transform one 8x8 block; sampled only in IDLE.
REQ-007 rd_row  output  3  pixel-row address into external image memory.
REQ-008 pix_row  input  64  eight unsigned 8-bit pixels of row rd_row, pixel k at bits [8k+7:8k], combinationally valid in the same cycle as rd_row.
REQ-009 coef_out  output  OUT_W  signed DCT coefficient Y[u][v].
REQ-010 coef_u, coef_v  output  3 each  vertical/horizontal frequency index of coef_out.
REQ-011 coef_valid  output  1  coef_out/coef_u/coef_v valid this cycle.
REQ-012 busy  output  1  high in PASS1 and PASS2.
REQ-013 done  output  1  one-cycle pulse, concurrent with the last coef_valid of a block.

Function
REQ-014 Computes Y = C*X*C^T, X = pixel-128 (9-bit signed), C = 8x8 orthonormal DCT-II matrix quantised to round(C*2^12).
REQ-015 FSM states IDLE, PASS1, PASS2; IDLE->PASS1 when start=1; PASS1->PASS2 after i=j=7; PASS2->IDLE after i=j=7.
REQ-016 Counters i (outer) and j (inner), 3 bits each; j increments every PASS cycle, i increments when j=7; both wrap 7->0 and clear on IDLE->PASS1.
REQ-017 PASS1 cycle (i,j): rd_row=i; T = sum_k X[i][k]*C[j][k] (25-bit accumulate), add 2^11, arithmetic shift right 12, truncate to TMP_W; written to internal buffer at Tt[j][i] at end of cycle.
REQ-018 PASS2 cycle (i,j): Y[i][j] = sum_k C[i][k]*Tt[j][k] (32-bit accumulate), add 2^11, arithmetic shift right 12, saturate to [-2048, 2047].
REQ-019 PASS2 result is registered: coef_valid=1, coef_u=i, coef_v=j, coef_out=Y one cycle after its PASS2 cycle; coef_valid=0 otherwise.
REQ-020 Output order raster: (0,0),(0,1)...(7,7); exactly 64 coef_valid pulses per block.
REQ-021 Latency: start accepted in cycle t -> PASS1 t+1..t+64, PASS2 t+65..t+128, coef_valid t+66..t+129, done at t+129.
REQ-022 start ignored while busy=1; start=1 in the IDLE cycle carrying done is accepted (back-to-back blocks, no gap beyond that cycle).
REQ-023 rd_row=0 outside PASS1.
REQ-024 Buffer Tt is read in PASS2 only after all 64 PASS1 writes; no read/write overlap.

Reset
REQ-025 rst=1 forces IDLE, i=j=0, coef_valid=0, done=0, busy=0, coef_out=0, coef_u=coef_v=0 immediately, regardless of clock.
REQ-026 Reset mid-PASS1/PASS2 abandons the block; no further coef_valid or done for it; Tt contents undefined and not cleared.
REQ-027 After rst deasserts, first start in IDLE begins a full new block.

Structure
REQ-028 Shared package holds COEF_W, FRAC, TMP_W, OUT_W, FSM state encoding and the 8x8 quantised coefficient table.
REQ-029 One sub-module dct_coef_rom: combinational, 3-bit row address in, 8 x COEF_W = 104-bit row out; instantiated twice (row j in PASS1, row i in PASS2) or time-shared via a mux.
REQ-030 Tt is an internal 8x8 x TMP_W register array, one row write-port element and one 8-word row read per cycle.

Verification
REQ-031 All pixels 128 -> 64 coef_valid, all coef_out=0, done at t+129.
REQ-032 All pixels 255 -> Y[0][0]=1016 +/-1, all other coefficients 0 +/-1; all pixels 0 -> Y[0][0]=-1024 +/-1, others 0 +/-1.
REQ-033 Random blocks (>=1000) -> coef_out bit-exact against a fixed-point model following REQ-017/018; order per REQ-020.
REQ-034 start pulsed at PASS1 cycle 10 and PASS2 cycle 30 -> ignored, single done per block; start held high -> blocks back-to-back, done spacing 129 cycles.
REQ-035 rst asserted at PASS2 cycle 20 -> coef_valid, busy, done drop same cycle; next start yields correct full block.
